// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the 6502 main-CPU memory-bus responder.
// Region priority and read-data selection live here so the top stays a plain FSM.
package cpu_bus_pkg;

    localparam int          LAT_W            = 3;
    localparam logic [13:0] ROM_BASE_DEFAULT = 14'h2000;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_ROM,
        REG_RAM,
        REG_IO
    } region_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_e;

    // ROM wins over RAM, RAM over I/O, when the decoder raises several selects.
    function automatic region_e pick_region(input logic rom, input logic ram, input logic io);
        if (rom)      return REG_ROM;
        else if (ram) return REG_RAM;
        else if (io)  return REG_IO;
        else          return REG_NONE;
    endfunction

    function automatic logic [7:0] pick_data(input region_e r, input logic [7:0] rom_d,
                                             input logic [7:0] ram_d, input logic [7:0] io_d);
        case (r)
            REG_ROM: return rom_d;
            REG_RAM: return ram_d;
            REG_IO:  return io_d;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/cpu_mem_responder_wait_counter.sv
// Loadable 3-bit wait-state down-counter; saturates at zero.
// zero flags the final wait cycle: the decrement taken this cycle empties the count.
module wait_counter
    import cpu_bus_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [LAT_W-1:0] load_val,
    output logic             zero
);

    logic [LAT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - LAT_W'(1);
        end
    end

    assign zero = (count <= LAT_W'(1));

endmodule

// File: rtl/cpu_mem_responder.sv
// Responder side of the 6502 main-CPU bus: drives ROM/RAM/I/O for one access at a time,
// holds the CPU via cpu_rdy and returns read data through a registered mux.
module cpu_mem_responder
    import cpu_bus_pkg::*;
#(
    parameter int unsigned ROM_LAT  = 2,
    parameter int unsigned RAM_LAT  = 1,
    parameter int unsigned IO_LAT   = 0,
    parameter logic [13:0] ROM_BASE = ROM_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [15:0] cpu_ab,
    input  logic        cpu_rw_l,
    input  logic [7:0]  cpu_do,
    input  logic        sel_rom,
    input  logic        sel_ram,
    input  logic        sel_io,
    output logic [7:0]  cpu_di,
    output logic        cpu_rdy,
    output logic        cpu_ack,
    output logic        rom_en,
    output logic [13:0] rom_addr,
    input  logic [7:0]  rom_dout,
    output logic        ram_en,
    output logic        ram_we,
    output logic [9:0]  ram_addr,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout,
    output logic        io_rd,
    output logic [7:0]  io_addr,
    input  logic [7:0]  io_din,
    output logic        illegal_wr,
    output logic        proto_err,
    output state_e      dbg_state
);

    // Handshake: an access is accepted on any cycle with cpu_req=1 while cpu_rdy=1 (IDLE);
    // cpu_rdy stays low until the cycle after the one-cycle cpu_ack pulse, and requests
    // seen while cpu_rdy=0 are dropped and flagged on proto_err.

    state_e           state;
    region_e          region_now;
    region_e          region_q;
    logic [LAT_W-1:0] lat_now;
    logic             accept;
    logic             is_read;
    logic             multi_sel;
    logic             need_wait;
    logic             cnt_zero;
    logic             unused_ab_hi;

    assign unused_ab_hi = ^cpu_ab[15:14];

    assign accept     = cpu_req && (state == IDLE);
    assign is_read    = cpu_rw_l;
    assign region_now = pick_region(sel_rom, sel_ram, sel_io);
    assign multi_sel  = (sel_rom & sel_ram) | (sel_rom & sel_io) | (sel_ram & sel_io);

    always_comb begin
        lat_now = '0;
        case (region_now)
            REG_ROM: lat_now = LAT_W'(ROM_LAT);
            REG_RAM: lat_now = LAT_W'(RAM_LAT);
            REG_IO:  lat_now = LAT_W'(IO_LAT);
            default: lat_now = '0;
        endcase
    end

    // Only reads of a real region ever wait; everything else acks the next cycle.
    assign need_wait = accept && is_read && (region_now != REG_NONE) && (lat_now != '0);

    assign rom_en   = accept && is_read && (region_now == REG_ROM);
    assign ram_en   = accept && (region_now == REG_RAM);
    assign ram_we   = ram_en && !is_read;
    assign io_rd    = accept && is_read && (region_now == REG_IO);
    assign rom_addr = cpu_ab[13:0] - ROM_BASE;
    assign ram_addr = cpu_ab[9:0];
    assign ram_din  = cpu_do;
    assign io_addr  = cpu_ab[7:0];

    wait_counter u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (need_wait),
        .en       (state == WAIT),
        .load_val (lat_now),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            region_q   <= REG_NONE;
            cpu_di     <= 8'h00;
            cpu_rdy    <= 1'b1;
            cpu_ack    <= 1'b0;
            illegal_wr <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            if (cpu_req && (state != IDLE)) begin
                proto_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        region_q <= region_now;
                        cpu_rdy  <= 1'b0;
                        if (multi_sel) begin
                            proto_err <= 1'b1;
                        end
                        if (!is_read && (region_now == REG_ROM)) begin
                            illegal_wr <= 1'b1;
                        end
                        if (need_wait) begin
                            state <= WAIT;
                        end else begin
                            // Zero-latency read samples now; unmapped reads leave cpu_di alone.
                            if (is_read && (region_now != REG_NONE)) begin
                                cpu_di <= pick_data(region_now, rom_dout, ram_dout, io_din);
                            end
                            state   <= DONE;
                            cpu_ack <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_zero) begin
                        cpu_di  <= pick_data(region_q, rom_dout, ram_dout, io_din);
                        state   <= DONE;
                        cpu_ack <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    cpu_rdy <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    cpu_rdy <= 1'b1;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: directed scenarios plus randomized accesses
// checked against an access-level model of regions, latencies, open-bus data and flags.
module tb_cpu_mem_responder;
    import cpu_bus_pkg::*;

    localparam int ROM_LAT = 2;
    localparam int RAM_LAT = 1;
    localparam int IO_LAT  = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic [15:0] cpu_ab = 16'h0000;
    logic        cpu_rw_l = 1'b1;
    logic [7:0]  cpu_do = 8'h00;
    logic        sel_rom = 1'b0, sel_ram = 1'b0, sel_io = 1'b0;
    logic [7:0]  cpu_di;
    logic        cpu_rdy, cpu_ack;
    logic        rom_en, ram_en, ram_we, io_rd;
    logic [13:0] rom_addr;
    logic [9:0]  ram_addr;
    logic [7:0]  ram_din, io_addr;
    logic [7:0]  rom_dout, ram_dout, io_din;
    logic        illegal_wr, proto_err;
    state_e      dbg_state;

    int checks   = 0;
    int failures = 0;

    cpu_mem_responder #(
        .ROM_LAT (ROM_LAT),
        .RAM_LAT (RAM_LAT),
        .IO_LAT  (IO_LAT),
        .ROM_BASE(14'h2000)
    ) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_ab(cpu_ab), .cpu_rw_l(cpu_rw_l),
        .cpu_do(cpu_do), .sel_rom(sel_rom), .sel_ram(sel_ram), .sel_io(sel_io),
        .cpu_di(cpu_di), .cpu_rdy(cpu_rdy), .cpu_ack(cpu_ack),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .io_rd(io_rd), .io_addr(io_addr), .io_din(io_din),
        .illegal_wr(illegal_wr), .proto_err(proto_err), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- memory device models ----------------
    // Sources present the real word only once their latency has elapsed, the inverse before.
    logic [7:0]  rom_mem [16384];
    logic [7:0]  io_mem  [256];
    logic [7:0]  ram_mem [1024];
    bit          ram_wr  [1024];
    logic [7:0]  ref_ram [1024];
    logic [13:0] rom_a = '0;
    logic [9:0]  ram_a = '0;
    int          rom_age = 100;
    int          ram_age = 100;

    function automatic logic [7:0] ram_pat(input logic [9:0] a);
        return a[7:0] ^ {a[9:8], 6'h15};
    endfunction

    always @(posedge clk) begin
        if (rom_en) begin
            rom_a   <= rom_addr;
            rom_age <= 0;
        end else if (rom_age < 100) begin
            rom_age <= rom_age + 1;
        end
    end

    always @(posedge clk) begin
        if (ram_en) begin
            ram_a   <= ram_addr;
            ram_age <= 0;
            if (ram_we) begin
                ram_mem[ram_addr] <= ram_din;
                ram_wr[ram_addr]  <= 1'b1;
            end
        end else if (ram_age < 100) begin
            ram_age <= ram_age + 1;
        end
    end

    logic [7:0] ram_word;
    assign ram_word = ram_wr[ram_a] ? ram_mem[ram_a] : ram_pat(ram_a);
    assign rom_dout = (rom_age + 1 >= ROM_LAT) ? rom_mem[rom_a] : ~rom_mem[rom_a];
    assign ram_dout = (ram_age + 1 >= RAM_LAT) ? ram_word : ~ram_word;
    assign io_din   = io_rd ? io_mem[io_addr] : ~io_mem[io_addr];

    // ---------------- reference model state ----------------
    logic [7:0] exp_di;
    logic       exp_illegal;
    logic       exp_proto;

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cpu_req = 1'b0;
        {sel_rom, sel_ram, sel_io} = 3'b000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_di = 8'h00;
        exp_illegal = 1'b0;
        exp_proto = 1'b0;
    endtask

    // Called at a falling edge; presents one request and returns what was observed.
    // en = {rom_en, ram_en, ram_we, io_rd} in the request cycle.
    task automatic issue(input logic [15:0] ab, input logic rw_l, input logic [7:0] dout,
                         input logic [2:0] sel, output logic [3:0] en, output logic [13:0] ra,
                         output logic [9:0] ma, output logic [7:0] md, output logic [7:0] ia,
                         output int ack_cyc, output logic [7:0] di, output logic rdy_ok,
                         output logic after_ok);
        cpu_req  = 1'b1;
        cpu_ab   = ab;
        cpu_rw_l = rw_l;
        cpu_do   = dout;
        {sel_rom, sel_ram, sel_io} = sel;
        #1;
        en = {rom_en, ram_en, ram_we, io_rd};
        ra = rom_addr;
        ma = ram_addr;
        md = ram_din;
        ia = io_addr;
        @(negedge clk);
        cpu_req = 1'b0;
        {sel_rom, sel_ram, sel_io} = 3'b000;
        ack_cyc = -1;
        di = 8'h00;
        rdy_ok = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            if (cpu_rdy !== 1'b0) rdy_ok = 1'b0;
            if (cpu_ack === 1'b1) begin
                ack_cyc = k;
                di = cpu_di;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        after_ok = (cpu_rdy === 1'b1) && (cpu_ack === 1'b0);
    endtask

    logic [3:0]  o_en;
    logic [13:0] o_ra;
    logic [9:0]  o_ma;
    logic [7:0]  o_md, o_ia, o_di;
    int          o_ack;
    logic        o_rdy_ok, o_after_ok;

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({cpu_di, cpu_rdy, cpu_ack} !== {8'h00, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs got=di%h rdy%b ack%b exp=di00 rdy1 ack0", cpu_di, cpu_rdy, cpu_ack);
        end
        checks++;
        if ({rom_en, ram_en, ram_we, io_rd, illegal_wr, proto_err, dbg_state} !== {6'b0, IDLE}) begin
            failures++;
            $display("FAIL reset_strobes_flags got=%b exp=000000 state IDLE",
                     {rom_en, ram_en, ram_we, io_rd, illegal_wr, proto_err});
        end
    endtask

    task automatic test_rom_read();
        issue(16'h2000, 1'b1, 8'h00, 3'b100, o_en, o_ra, o_ma, o_md, o_ia, o_ack, o_di, o_rdy_ok, o_after_ok);
        checks++;
        if ({o_en, o_ra} !== {4'b1000, 14'h0000}) begin
            failures++;
            $display("FAIL rom_read_strobe got=en%b addr%h exp=en1000 addr0000", o_en, o_ra);
        end
        checks++;
        if (o_ack !== 3 || o_di !== 8'hA9) begin
            failures++;
            $display("FAIL rom_read_ack got=cyc%0d di%h exp=cyc3 diA9", o_ack, o_di);
        end
        checks++;
        if (!(o_rdy_ok && o_after_ok)) begin
            failures++;
            $display("FAIL rom_read_rdy got=busy_low%b idle_after%b exp=1 1", o_rdy_ok, o_after_ok);
        end
        exp_di = 8'hA9;
    endtask

    task automatic test_unmapped_read();
        issue(16'hF000, 1'b1, 8'h00, 3'b000, o_en, o_ra, o_ma, o_md, o_ia, o_ack, o_di, o_rdy_ok, o_after_ok);
        checks++;
        if (o_en !== 4'b0000 || o_ack !== 1 || o_di !== exp_di || !o_after_ok) begin
            failures++;
            $display("FAIL unmapped_read got=en%b cyc%0d di%h exp=en0000 cyc1 di%h", o_en, o_ack, o_di, exp_di);
        end
    endtask

    task automatic test_ram_write_read();
        issue(16'h0010, 1'b0, 8'h55, 3'b010, o_en, o_ra, o_ma, o_md, o_ia, o_ack, o_di, o_rdy_ok, o_after_ok);
        ref_ram[10'h010] = 8'h55;
        checks++;
        if ({o_en, o_ma, o_md} !== {4'b0110, 10'h010, 8'h55} || o_ack !== 1) begin
            failures++;
            $display("FAIL ram_write got=en%b addr%h din%h cyc%0d exp=en0110 addr010 din55 cyc1",
                     o_en, o_ma, o_md, o_ack);
        end
        issue(16'h0010, 1'b1, 8'h00, 3'b010, o_en, o_ra, o_ma, o_md, o_ia, o_ack, o_di, o_rdy_ok, o_after_ok);
        checks++;
        if (o_en !== 4'b0100 || o_ack !== 2 || o_di !== 8'h55 || !o_rdy_ok) begin
            failures++;
            $display("FAIL ram_read got=en%b cyc%0d di%h exp=en0100 cyc2 di55", o_en, o_ack, o_di);
        end
        exp_di = 8'h55;
    endtask

    task automatic test_rom_write();
        issue(16'h3FFF, 1'b0, 8'h12, 3'b100, o_en, o_ra, o_ma, o_md, o_ia, o_ack, o_di, o_rdy_ok, o_after_ok);
        checks++;
        if (o_en !== 4'b0000 || o_ack !== 1 || illegal_wr !== 1'b1) begin
            failures++;
            $display("FAIL rom_write got=en%b cyc%0d illegal%b exp=en0000 cyc1 illegal1", o_en, o_ack, illegal_wr);
        end
        issue(16'h0200, 1'b1, 8'h00, 3'b000, o_en, o_ra, o_ma, o_md, o_ia, o_ack, o_di, o_rdy_ok, o_after_ok);
        checks++;
        if (illegal_wr !== 1'b1 || o_di !== exp_di) begin
            failures++;
            $display("FAIL illegal_sticky got=illegal%b di%h exp=illegal1 di%h", illegal_wr, o_di, exp_di);
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        cpu_req = 1'b1; cpu_ab = 16'h2000; cpu_rw_l = 1'b1; sel_rom = 1'b1;
        @(negedge clk);
        cpu_req = 1'b0; sel_rom = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({cpu_rdy, cpu_ack, cpu_di, illegal_wr} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL reset_midflight got=rdy%b ack%b di%h ill%b exp=rdy1 ack0 di00 ill0",
                     cpu_rdy, cpu_ack, cpu_di, illegal_wr);
        end
        exp_di = 8'h00; exp_illegal = 1'b0; exp_proto = 1'b0;
        issue(16'h4023, 1'b1, 8'h00, 3'b001, o_en, o_ra, o_ma, o_md, o_ia, o_ack, o_di, o_rdy_ok, o_after_ok);
        checks++;
        if ({o_en, o_ia} !== {4'b0001, 8'h23} || o_ack !== 1 || o_di !== 8'h7E || !o_after_ok) begin
            failures++;
            $display("FAIL io_read got=en%b addr%h cyc%0d di%h exp=en0001 addr23 cyc1 di7E", o_en, o_ia, o_ack, o_di);
        end
        exp_di = 8'h7E;
    endtask

    task automatic test_multi_select();
        do_reset();
        issue(16'h0010, 1'b1, 8'h00, 3'b011, o_en, o_ra, o_ma, o_md, o_ia, o_ack, o_di, o_rdy_ok, o_after_ok);
        checks++;
        if (o_en !== 4'b0100 || o_ack !== 2 || o_di !== ref_ram[10'h010] || proto_err !== 1'b1) begin
            failures++;
            $display("FAIL multi_select got=en%b cyc%0d di%h perr%b exp=en0100 cyc2 di%h perr1",
                     o_en, o_ack, o_di, proto_err, ref_ram[10'h010]);
        end
    endtask

    task automatic test_busy_req();
        logic seen_en;
        logic [7:0] exp_rom;
        do_reset();
        exp_rom = rom_mem[14'h0005];
        seen_en = 1'b0;
        cpu_req = 1'b1; cpu_ab = 16'h2005; cpu_rw_l = 1'b1; sel_rom = 1'b1;
        @(negedge clk);
        cpu_ab = 16'h0030; cpu_rw_l = 1'b0; cpu_do = 8'hEE; sel_rom = 1'b0; sel_ram = 1'b1;
        #1 seen_en = seen_en | ram_en | rom_en;
        @(negedge clk);
        checks++;
        if (cpu_ack !== 1'b0) begin
            failures++;
            $display("FAIL busy_early_ack got=%b exp=0", cpu_ack);
        end
        @(negedge clk);
        checks++;
        if (cpu_ack !== 1'b1 || cpu_di !== exp_rom) begin
            failures++;
            $display("FAIL busy_rom_ack got=ack%b di%h exp=ack1 di%h", cpu_ack, cpu_di, exp_rom);
        end
        #1 seen_en = seen_en | ram_en | rom_en;
        @(negedge clk);
        cpu_req = 1'b0; sel_ram = 1'b0;
        checks++;
        if (seen_en !== 1'b0 || cpu_ack !== 1'b0 || cpu_rdy !== 1'b1 || proto_err !== 1'b1 || illegal_wr !== 1'b0) begin
            failures++;
            $display("FAIL busy_ignored got=en%b ack%b rdy%b perr%b ill%b exp=en0 ack0 rdy1 perr1 ill0",
                     seen_en, cpu_ack, cpu_rdy, proto_err, illegal_wr);
        end
        checks++;
        if ((ram_wr[10'h030] ? ram_mem[10'h030] : ram_pat(10'h030)) !== ref_ram[10'h030]) begin
            failures++;
            $display("FAIL busy_ram_untouched got=%h exp=%h", ram_mem[10'h030], ref_ram[10'h030]);
        end
        exp_di = exp_rom;
    endtask

    task automatic test_random();
        logic [15:0] ab;
        logic        rw;
        logic [7:0]  d;
        logic [2:0]  sel;
        logic [13:0] rom_off;
        logic [3:0]  exp_en;
        int          exp_ack;
        int          lat;
        do_reset();
        for (int n = 0; n < 80; n++) begin
            ab  = 16'($urandom_range(0, 65535));
            rw  = 1'($urandom_range(0, 1));
            d   = 8'($urandom_range(0, 255));
            sel = (n % 4 == 0) ? 3'($urandom_range(0, 7)) : (3'b001 << $urandom_range(0, 2));
            rom_off = ab[13:0] - 14'h2000;
            // Expected behaviour from the access-level rules.
            exp_en = 4'b0000;
            lat = 0;
            if (sel[2]) begin
                exp_en[3] = rw;
                lat = ROM_LAT;
                if (rw) exp_di = rom_mem[rom_off];
                else    exp_illegal = 1'b1;
            end else if (sel[1]) begin
                exp_en[2] = 1'b1;
                exp_en[1] = !rw;
                lat = RAM_LAT;
                if (rw) exp_di = ref_ram[ab[9:0]];
            end else if (sel[0]) begin
                exp_en[0] = rw;
                lat = IO_LAT;
                if (rw) exp_di = io_mem[ab[7:0]];
            end
            exp_ack = (rw && sel != 3'b000) ? lat + 1 : 1;
            if ((sel[2] & sel[1]) | (sel[2] & sel[0]) | (sel[1] & sel[0])) exp_proto = 1'b1;
            issue(ab, rw, d, sel, o_en, o_ra, o_ma, o_md, o_ia, o_ack, o_di, o_rdy_ok, o_after_ok);
            if (sel[2] == 1'b0 && sel[1] && !rw) ref_ram[ab[9:0]] = d;
            checks++;
            if (o_en !== exp_en || o_ra !== rom_off || o_ma !== ab[9:0] || o_ia !== ab[7:0] || o_md !== d) begin
                failures++;
                $display("FAIL rand_strobes n=%0d got=en%b ra%h ma%h ia%h md%h exp=en%b ra%h ma%h ia%h md%h",
                         n, o_en, o_ra, o_ma, o_ia, o_md, exp_en, rom_off, ab[9:0], ab[7:0], d);
            end
            checks++;
            if (o_ack !== exp_ack || o_di !== exp_di || !o_rdy_ok || !o_after_ok) begin
                failures++;
                $display("FAIL rand_response n=%0d got=cyc%0d di%h rdy%b%b exp=cyc%0d di%h rdy11",
                         n, o_ack, o_di, o_rdy_ok, o_after_ok, exp_ack, exp_di);
            end
            checks++;
            if (illegal_wr !== exp_illegal || proto_err !== exp_proto) begin
                failures++;
                $display("FAIL rand_flags n=%0d got=ill%b perr%b exp=ill%b perr%b",
                         n, illegal_wr, proto_err, exp_illegal, exp_proto);
            end
        end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        for (int i = 0; i < 16384; i++) rom_mem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 256; i++)   io_mem[i]  = 8'($urandom_range(0, 255));
        for (int i = 0; i < 1024; i++)  ref_ram[i] = ram_pat(10'(i));
        rom_mem[0]     = 8'hA9;
        io_mem[8'h23]  = 8'h7E;
        exp_di = 8'h00; exp_illegal = 1'b0; exp_proto = 1'b0;

        test_reset();
        test_rom_read();
        test_unmapped_read();
        test_ram_write_read();
        test_rom_write();
        test_reset_midflight();
        test_multi_select();
        test_busy_req();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
